packetizer_serial: RTL

- Sequential successor to the parallel 4-flit packetizer.
- Accepts one message word with destination and VC, splits it into NUM_FLITS flits, and emits one flit per cycle on a narrow NoC injection port.
- Flit count, flit width and message width are parametrised.
- Input and output both use valid/ready handshakes; the output is registered.
- Sits between a translator/module output and a NoC router input port.

---
 rtl/packetizer_serial.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/packetizer_serial.sv
// packetizer_serial: splits one message (payload + dst + vc) into NUM_FLITS
//   flits and emits them one per cycle onto a NoC injection port.
// Latency: head flit on data_out the cycle after acceptance; NUM_FLITS
//   cycles per message when ready_in is held high.
// Backpressure: valid_out && !ready_in freezes the flit, counter and latched
//   message. ready_out is high when idle or while the tail is being accepted.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   data_in/dst_in/vc_in  message payload, destination router, virtual channel
//   valid_in / ready_out  message handshake
//   data_out / valid_out  registered flit {valid, head, tail, vc, [dst], payload, pad}
//   ready_in              downstream accepts the presented flit
//   pkt_count/flit_count  present only when PACKETIZER_SERIAL_STATS_EN is defined
//
// Optional feature macro: PACKETIZER_SERIAL_STATS_EN (wrapping 16-bit packet and
// flit handshake counters).

module packetizer_serial #(
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int WIDTH_IN         = 64,
  parameter int FLIT_WIDTH       = 36
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIDTH_IN-1:0]         data_in,
  input  logic [ADDRESS_WIDTH-1:0]    dst_in,
  input  logic [VC_ADDRESS_WIDTH-1:0] vc_in,
  input  logic                        valid_in,
  output logic                        ready_out,
  output logic [FLIT_WIDTH-1:0]       data_out,
  output logic                        valid_out,
`ifdef PACKETIZER_SERIAL_STATS_EN
  output logic [15:0]                 pkt_count,
  output logic [15:0]                 flit_count,
`endif
  input  logic                        ready_in
);

  localparam int HEAD_PAYLOAD = FLIT_WIDTH - 3 - VC_ADDRESS_WIDTH - ADDRESS_WIDTH;
  localparam int BODY_PAYLOAD = FLIT_WIDTH - 3 - VC_ADDRESS_WIDTH;
  localparam int NUM_FLITS    = (WIDTH_IN <= HEAD_PAYLOAD) ? 1 :
      1 + (WIDTH_IN - HEAD_PAYLOAD + BODY_PAYLOAD - 1) / BODY_PAYLOAD;
  localparam int CNT_W        = $clog2(NUM_FLITS) + 1;
  // Padded message carries one spare body slot so the body slice below is
  // always in range, even for single-flit configurations.
  localparam int PAD_W        = HEAD_PAYLOAD + NUM_FLITS * BODY_PAYLOAD;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_FLITS - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t                      r_state, w_state_nxt;
  logic [CNT_W-1:0]            r_cnt, w_cnt_nxt;
  logic [FLIT_WIDTH-1:0]       r_data, w_data_nxt;
  logic [WIDTH_IN-1:0]         r_msg, w_msg_nxt;
  logic [ADDRESS_WIDTH-1:0]    r_dst, w_dst_nxt;
  logic [VC_ADDRESS_WIDTH-1:0] r_vc, w_vc_nxt;

  logic w_is_tail;
  logic w_accept;
  logic w_hs;

  // Builds flit number idx of a message. Payload is consumed MSB-first; the
  // zero padding appended below the message lands in the LSBs of the tail.
  function automatic logic [FLIT_WIDTH-1:0] build_flit(
    input logic [WIDTH_IN-1:0]         msg,
    input logic [ADDRESS_WIDTH-1:0]    dst,
    input logic [VC_ADDRESS_WIDTH-1:0] vc,
    input logic [CNT_W-1:0]            idx
  );
    logic [PAD_W-1:0] pad;
    logic [PAD_W-1:0] shifted;
    logic             tail;
    int               sh;
    pad  = {msg, {(PAD_W - WIDTH_IN){1'b0}}};
    tail = (idx == LAST_IDX);
    if (idx == '0) begin
      build_flit = {1'b1, 1'b1, tail, vc, dst, pad[PAD_W-1 -: HEAD_PAYLOAD]};
    end else begin
      sh         = HEAD_PAYLOAD + (int'(idx) - 1) * BODY_PAYLOAD;
      shifted    = pad << sh;
      build_flit = {1'b1, 1'b0, tail, vc, shifted[PAD_W-1 -: BODY_PAYLOAD]};
    end
  endfunction

  assign valid_out = (r_state == S_SEND);
  assign data_out  = r_data;
  assign w_is_tail = (r_cnt == LAST_IDX);
  // Only the tail-flit case looks at ready_in, which is what allows a new
  // message to be taken on the same edge the tail leaves.
  assign ready_out = !valid_out || (w_is_tail && ready_in);
  assign w_accept  = valid_in && ready_out;
  assign w_hs      = valid_out && ready_in;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data;
    w_msg_nxt   = r_msg;
    w_dst_nxt   = r_dst;
    w_vc_nxt    = r_vc;
    if (w_accept) begin
      w_msg_nxt   = data_in;
      w_dst_nxt   = dst_in;
      w_vc_nxt    = vc_in;
      w_cnt_nxt   = '0;
      w_data_nxt  = build_flit(data_in, dst_in, vc_in, '0);
      w_state_nxt = S_SEND;
    end else if (w_hs) begin
      if (w_is_tail) begin
        w_cnt_nxt   = '0;
        w_data_nxt  = '0;
        w_state_nxt = S_IDLE;
      end else begin
        w_cnt_nxt  = r_cnt + CNT_W'(1);
        w_data_nxt = build_flit(r_msg, r_dst, r_vc, r_cnt + CNT_W'(1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
      r_msg   <= '0;
      r_dst   <= '0;
      r_vc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_data  <= w_data_nxt;
      r_msg   <= w_msg_nxt;
      r_dst   <= w_dst_nxt;
      r_vc    <= w_vc_nxt;
    end
  end

`ifdef PACKETIZER_SERIAL_STATS_EN
  logic [15:0] r_pkt_count;
  logic [15:0] r_flit_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_count  <= '0;
      r_flit_count <= '0;
    end else if (w_hs) begin
      r_flit_count <= r_flit_count + 16'd1;
      if (w_is_tail) begin
        r_pkt_count <= r_pkt_count + 16'd1;
      end
    end
  end

  assign pkt_count  = r_pkt_count;
  assign flit_count = r_flit_count;
`endif

endmodule
